// File: rtl/elink_trig_pkg.sv
// Shared definitions for the trigger-elink scrub path: sweeper FSM states and
// the address/data width defaults shared with elink_trig_scrubber.
package elink_trig_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK,
        DONE
    } sweep_state_t;

endpackage

// File: rtl/elink_trig_scrub_timer.sv
// Period down-counter for automatic scrub sweeps. Built only when
// ELINK_TRIG_SCRUB_AUTO_EN is defined.
module elink_trig_scrub_timer #(
    parameter int PERIOD = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(PERIOD + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RELOAD;
        end else if (load) begin
            count <= RELOAD;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Expiry lands PERIOD cycles after the reload so the sweep starts exactly then.
    assign expire = en && !load && (count == '0);

endmodule

// File: rtl/elink_trig_scrub_sweeper.sv
// Wishbone read master that sweeps every trigger-elink register, compares
// against a golden table and reports errors. Optional macro: ELINK_TRIG_SCRUB_AUTO_EN.
module elink_trig_scrub_sweeper
    import elink_trig_pkg::*;
#(
    parameter int N_ADDR  = 16,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ERR_W   = 8,
    parameter int TIMEOUT = 15,
    parameter int PERIOD  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic              o_wb_stb,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_wb_ack,
    input  logic              i_wb_stall,
    output logic [ADDR_W-1:0] o_golden_addr,
    input  logic [DATA_W-1:0] i_golden_data,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_count,
    output logic              err_flag,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              timeout_flag
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ADDR - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    sweep_state_t      state, state_next;
    logic [ADDR_W-1:0] addr;
    logic [TO_W-1:0]   to_cnt;
    logic              ack_pend;
    logic [DATA_W-1:0] data_pend;
    logic [DATA_W-1:0] rd_data;
    logic              trigger, accept, ack_seen, timed_out, xact_end, err_evt;

`ifdef ELINK_TRIG_SCRUB_AUTO_EN
    logic timer_load, timer_en, period_expire;

    assign timer_load = (state == DONE) || start;
    assign timer_en   = (state == IDLE);

    elink_trig_scrub_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .en     (timer_en),
        .expire (period_expire)
    );

    assign trigger = start || period_expire;
`else
    assign trigger = start;
`endif

    assign accept    = (state == REQ) && !i_wb_stall;
    // An ack captured in the acceptance cycle stands in for the live ack.
    assign ack_seen  = (state == ACK) && (ack_pend || i_wb_ack);
    assign rd_data   = ack_pend ? data_pend : i_wb_data;
    assign timed_out = (state == ACK) && !ack_seen && (to_cnt == TO_LAST);
    assign xact_end  = ack_seen || timed_out;
    assign err_evt   = (ack_seen && (rd_data != i_golden_data)) || timed_out;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger) state_next = REQ;
            REQ:     if (accept) state_next = ACK;
            ACK:     if (xact_end) state_next = (addr == LAST_ADDR) ? DONE : REQ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr     <= '0;
            to_cnt   <= '0;
            ack_pend <= 1'b0;
            o_wb_stb <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            o_wb_stb <= (state_next == REQ);
            busy     <= (state_next != IDLE);
            done     <= (state_next == DONE);

            if ((state == IDLE) && trigger) begin
                addr <= '0;
            end else if ((state == ACK) && xact_end && (addr != LAST_ADDR)) begin
                addr <= addr + 1'b1;
            end

            if (accept) begin
                to_cnt <= '0;
            end else if ((state == ACK) && !xact_end) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (accept) begin
                ack_pend <= i_wb_ack;
            end else if ((state == ACK) && xact_end) begin
                ack_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_pend <= i_wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count      <= '0;
            err_flag       <= 1'b0;
            first_err_addr <= '0;
            timeout_flag   <= 1'b0;
        end else if ((state == IDLE) && trigger) begin
            err_count      <= '0;
            err_flag       <= 1'b0;
            first_err_addr <= '0;
            timeout_flag   <= 1'b0;
        end else if (err_evt) begin
            if (err_count != ERR_MAX) begin
                err_count <= err_count + 1'b1;
            end
            err_flag <= 1'b1;
            if (!err_flag) begin
                first_err_addr <= addr;
            end
            if (timed_out) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign o_wb_addr     = addr;
    assign o_golden_addr = addr;

endmodule

// File: tb/tb_elink_trig_scrub_sweeper.sv
// Directed bench for elink_trig_scrub_sweeper: a reactive Wishbone slave plus
// address and result scoreboards filled when each sweep is launched.
module tb_elink_trig_scrub_sweeper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] o_wb_addr;
    logic       o_wb_stb;
    logic [9:0] i_wb_data;
    logic       i_wb_ack;
    logic       i_wb_stall;
    logic [3:0] o_golden_addr;
    logic [9:0] i_golden_data;
    logic       busy;
    logic       done;
    logic [2:0] err_count;
    logic       err_flag;
    logic [3:0] first_err_addr;
    logic       timeout_flag;

    typedef struct {
        logic [2:0] cnt;
        logic       flag;
        logic [3:0] first;
        logic       to;
        int         lat;
    } res_t;

    int   exp_q[$];
    res_t res_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   start_cyc = 0;

    logic [15:0] mism;
    int stall_addr, stall_n, noack_addr, mid_start_at;
    bit early;

    elink_trig_scrub_sweeper #(
        .N_ADDR (16), .ADDR_W (4), .DATA_W (10), .ERR_W (3), .TIMEOUT (15), .PERIOD (64)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .o_wb_addr      (o_wb_addr),
        .o_wb_stb       (o_wb_stb),
        .i_wb_data      (i_wb_data),
        .i_wb_ack       (i_wb_ack),
        .i_wb_stall     (i_wb_stall),
        .o_golden_addr  (o_golden_addr),
        .i_golden_data  (i_golden_data),
        .busy           (busy),
        .done           (done),
        .err_count      (err_count),
        .err_flag       (err_flag),
        .first_err_addr (first_err_addr),
        .timeout_flag   (timeout_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] golden(input logic [3:0] a);
        logic [9:0] v;
        v = {6'd0, a} * 10'd77 + 10'd13;
        return v ^ 10'h2B5;
    endfunction

    function automatic logic [9:0] resp(input logic [3:0] a);
        return golden(a) ^ {9'd0, mism[a]};
    endfunction

    assign i_golden_data = golden(o_golden_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cfg(input logic [15:0] m, input int s_addr, input int s_n,
                       input int na, input bit e, input int ms);
        mism = m; stall_addr = s_addr; stall_n = s_n;
        noack_addr = na; early = e; mid_start_at = ms;
    endtask

    // Independent model of the expected sweep result from the slave configuration.
    function automatic res_t model();
        res_t r;
        int e;
        e = 0; r.first = 4'd0; r.flag = 1'b0;
        for (int a = 0; a < 16; a++) begin
            if (mism[a] || (a == noack_addr)) begin
                if (!r.flag) r.first = 4'(a);
                r.flag = 1'b1;
                e++;
            end
        end
        r.cnt = 3'((e > 7) ? 7 : e);
        r.to  = (noack_addr >= 0);
        r.lat = 33 + stall_n + ((noack_addr >= 0) ? 14 : 0);
        return r;
    endfunction

    task automatic begin_sweep(input bit with_res);
        for (int a = 0; a < 16; a++) exp_q.push_back(a);
        if (with_res) res_q.push_back(model());
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic run_sweep(input int abort_addr);
        bit   pending, aborting, got_done;
        logic [3:0] pend_addr;
        int   stall_left, acc_to, to_seen, stb_stall, e;
        res_t r;
        pending = 0; aborting = 0; got_done = 0; pend_addr = '0;
        stall_left = stall_n; acc_to = -1; to_seen = -1; stb_stall = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            start = (n == mid_start_at);
            i_wb_ack = 1'b0;
            i_wb_stall = 1'b0;
            if (aborting) return;
            if (timeout_flag && (to_seen < 0)) to_seen = cyc;
            if (pending) begin
                i_wb_ack = 1'b1;
                i_wb_data = resp(pend_addr);
                pending = 0;
            end
            if (o_wb_stb && (int'(o_wb_addr) == stall_addr)) begin
                stb_stall++;
                if (stall_left > 0) begin
                    i_wb_stall = 1'b1;
                    stall_left--;
                end
            end
            if (o_wb_stb && !i_wb_stall) begin
                if (exp_q.size() == 0) begin
                    check("req_expected", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("req_addr", o_wb_addr, e);
                end
                if (int'(o_wb_addr) == noack_addr) begin
                    acc_to = cyc;
                end else if (early) begin
                    i_wb_ack = 1'b1;
                    i_wb_data = resp(o_wb_addr);
                end else begin
                    pending = 1;
                    pend_addr = o_wb_addr;
                end
                if (int'(o_wb_addr) == abort_addr) aborting = 1;
            end
            if (done) begin
                got_done = 1;
                break;
            end
        end
        start = 1'b0;
        i_wb_ack = 1'b0;
        i_wb_stall = 1'b0;
        check("done_seen", got_done, 1);
        r = res_q.pop_front();
        check("done_latency", cyc - start_cyc, r.lat);
        check("err_count", err_count, r.cnt);
        check("err_flag", err_flag, r.flag);
        check("first_err_addr", first_err_addr, r.first);
        check("timeout_flag", timeout_flag, r.to);
        check("leftover_reqs", exp_q.size(), 0);
        if (stall_n > 0) check("stall_stb_cycles", stb_stall, stall_n + 1);
        if (noack_addr >= 0) check("timeout_delay", to_seen - acc_to, 16);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stb"}, o_wb_stb, 0);
        check({tag, "_addr"}, o_wb_addr, 0);
        check({tag, "_golden_addr"}, o_golden_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_err_flag"}, err_flag, 0);
        check({tag, "_first_err"}, first_err_addr, 0);
        check({tag, "_timeout"}, timeout_flag, 0);
    endtask

    initial begin
        int extra_done, d_cyc;
        rst_n = 1'b0; start = 1'b0; i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_data = '0;
        cfg(16'h0000, -1, 0, -1, 0, -1);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // Clean sweep.
        begin_sweep(1);
        run_sweep(-1);

        // Mismatches at 5 and 9, then a stray ack while idle.
        cfg(16'h0220, -1, 0, -1, 0, -1);
        begin_sweep(1);
        run_sweep(-1);
        i_wb_ack = 1'b1; i_wb_data = 10'h3FF;
        @(negedge clk);
        i_wb_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_err_count", err_count, 2);
        check("idle_ack_busy", busy, 0);

        // Ack in the acceptance cycle, with a mismatch at 4.
        cfg(16'h0010, -1, 0, -1, 1, -1);
        begin_sweep(1);
        run_sweep(-1);

        // Three stall cycles at address 3.
        cfg(16'h0000, 3, 3, -1, 0, -1);
        begin_sweep(1);
        run_sweep(-1);

        // No ack at address 2.
        cfg(16'h0000, -1, 0, 2, 0, -1);
        begin_sweep(1);
        run_sweep(-1);

        // All addresses mismatch; start pulsed mid-sweep.
        cfg(16'hFFFF, -1, 0, -1, 0, 10);
        begin_sweep(1);
        run_sweep(-1);
        extra_done = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check("no_restart_done", extra_done, 0);
        check("no_restart_busy", busy, 0);

        // Reset during ACK at address 7 after an earlier error.
        cfg(16'h0002, -1, 0, -1, 0, -1);
        begin_sweep(0);
        run_sweep(7);
        check("abort_busy_before", busy, 1);
        check("abort_err_before", err_count, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Recovery sweep.
        cfg(16'h0000, -1, 0, -1, 0, -1);
        begin_sweep(1);
        run_sweep(-1);

`ifdef ELINK_TRIG_SCRUB_AUTO_EN
        // Automatic sweep 64 cycles after IDLE entry (done cycle + 1).
        d_cyc = cyc - 1;
        for (int n = 0; n < 120; n++) begin
            if (o_wb_stb) break;
            @(negedge clk);
        end
        check("auto_start_delay", cyc - d_cyc, 65);
`else
        d_cyc = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elink_trig_scrub_sweeper.md
# elink_trig_scrub_sweeper

Wishbone read master that sits directly upstream of `elink_trig_scrubber`. It sweeps every trigger-elink register address, compares each returned 10-bit word against a golden value and reports mismatches and timeouts. The results drive the scrub status path toward slow control.

## Interface
Parameters:
- `N_ADDR`, 16 — number of addresses swept, 0..N_ADDR-1 (≤ 2^ADDR_W).
- `ADDR_W`, 4 — Wishbone address width.
- `DATA_W`, 10 — Wishbone data width.
- `ERR_W`, 8 — width of the error counter.
- `TIMEOUT`, 15 — maximum cycles waited for ack after a request is accepted.
- `PERIOD`, 1024 — cycles between automatic sweeps (auto mode only).

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous active-low reset.
- `start` in 1 — single-cycle sweep request.
- `o_wb_addr` out ADDR_W — read address to scrubber.
- `o_wb_stb` out 1 — request strobe.
- `i_wb_data` in DATA_W — read data from scrubber.
- `i_wb_ack` in 1 — read acknowledge.
- `i_wb_stall` in 1 — slave not accepting requests.
- `o_golden_addr` out ADDR_W — index into the golden table; always equals `o_wb_addr`.
- `i_golden_data` in DATA_W — golden word for `o_golden_addr`, combinational.
- `busy` out 1 — sweep in progress.
- `done` out 1 — one-cycle pulse at sweep end.
- `err_count` out ERR_W — mismatches plus timeouts, saturating.
- `err_flag` out 1 — at least one error in the last sweep.
- `first_err_addr` out ADDR_W — address of the first error in the last sweep.
- `timeout_flag` out 1 — at least one timeout in the last sweep.

## Operation
- FSM states: IDLE, REQ, ACK, DONE.
- **IDLE**
  - A trigger is `start`=1, or the period timer expiring in auto mode.
  - On a trigger: clear `err_count`, `err_flag`, `first_err_addr` and `timeout_flag`; set addr=0; go to REQ.
- **REQ**
  - `o_wb_stb`=1 and `o_wb_addr` is held stable.
  - The request is accepted on the cycle where `o_wb_stb` && !`i_wb_stall`; the FSM then goes to ACK and clears the timeout counter.
  - While stalled, stb and addr are held.
- **ACK**
  - `o_wb_stb`=0.
  - `i_wb_ack` is honoured from the acceptance cycle onward. An ack arriving in the acceptance cycle itself is latched and used on the next cycle.
  - On ack: compare `i_wb_data` with `i_golden_data`.
  - If the timeout counter reaches TIMEOUT with no ack, record a timeout: `timeout_flag`=1, and it counts as an error.
  - After either ack or timeout: if addr==N_ADDR-1 go to DONE, otherwise addr+1 and go to REQ.
- **On any error**
  - `err_count` increments, saturating at 2^ERR_W-1.
  - `err_flag` is set.
  - `first_err_addr` is written only if `err_flag` was previously 0.
- **DONE**
  - `done`=1 for exactly one cycle, then the FSM returns to IDLE.
- **Busy and boundary rules**
  - `busy`=1 in REQ, ACK and DONE.
  - `start` while busy is ignored; it is neither queued nor restarts the sweep.
  - Result outputs hold their value until the next sweep starts.
  - An ack received in IDLE, or a second ack in the same transaction, is ignored.

## Timing
- Reset value of every output is 0 (state IDLE, addr 0). Reset is asynchronous, so `o_wb_stb` drops immediately when `rst_n` falls, including mid-sweep; no partial results survive.
- IDLE→REQ happens on the edge after `start`, so `o_wb_stb` is high in cycle start+1.
- With no stall and ack one cycle after acceptance, each address takes 2 cycles. A 16-address sweep puts `done` at cycle start+33.
- Result registers update on the edge after the ack or timeout cycle. They are final when `done` is high.
- All outputs are registered except `o_golden_addr`, which is a copy of the `o_wb_addr` register.

## Configuration
- `ELINK_TRIG_SCRUB_AUTO_EN` defined:
  - An internal counter triggers a sweep every PERIOD cycles, counted from the end of the previous sweep (IDLE entry).
  - `start` still forces an immediate sweep and reloads the counter.
- Undefined:
  - No period counter is built.
  - Sweeps occur only on `start`, and PERIOD is unused.

## Structure
- Package `elink_trig_pkg` holds:
  - the FSM state enum;
  - the `ADDR_W`/`DATA_W` defaults shared with `elink_trig_scrubber`.
- One sub-module, `elink_trig_scrub_timer`:
  - the PERIOD down-counter with load/expire;
  - instantiated only under `ELINK_TRIG_SCRUB_AUTO_EN`.
- The timeout counter stays inline.

## Test plan
- Clean sweep: golden equals slave data, ack one cycle after acceptance → `done` at start+33, `err_count`=0, `err_flag`=0, addresses 0..15 each requested exactly once.
- Mismatches: slave returns the golden value XOR 1 at addresses 5 and 9 → `err_count`=2, `first_err_addr`=5, `err_flag`=1, `timeout_flag`=0.
- Stall: `i_wb_stall` high for 3 cycles at address 3 → `o_wb_stb` stays high with `o_wb_addr`=3 for 4 cycles, exactly one acceptance, sweep completes.
- Timeout: no ack for address 2 → after 15 cycles `timeout_flag`=1, `err_count`=1, `first_err_addr`=2, then address 3 is requested and `done` still pulses.
- Saturation and start-while-busy: ERR_W=3 with all 16 addresses mismatching → `err_count`=7; a `start` pulsed mid-sweep → no restart, exactly one `done`.
- Reset and auto mode: `rst_n` low during ACK at address 7 → all outputs 0 immediately. With the macro and PERIOD=64 → the next sweep starts 64 cycles after IDLE entry.
